sqrt_div_sequencer: RTL
=======================

# sqrt_div_sequencer

Control FSM for the shared remainder/quotient shift-register datapath. It sequences a non-restoring integer divide or square root over the R and Q shift registers and the add/subtract ALU, using the datapath's load, shift, snum and Sync_Reset controls. It sits between the bus-side command interface (start/op/done) and the arithmetic datapath. It holds no operand data, only state, the iteration counter and the latched op.

## Interface
- WORD_LENGTH, 16: datapath width. Must be even and ≥ 4.
- CNT_W, $clog2(WORD_LENGTH)+1: iteration counter width. Derived; do not override.

- clk  in  1  clock. All state changes on rising edge.
- reset  in  1  synchronous, active-high reset. Sampled on the rising edge of clk; overrides every other input.
- start  in  1  command request. Accepted only in IDLE.
- op  in  1  0 = divide, 1 = square root. Latched on accepted start.
- div_zero  in  1  divisor equals zero. Sampled in LOAD only.
- res_sign  in  1  sign bit of the current ALU result (combinational from datapath).
- r_sign  in  1  sign bit of the R register.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- error  out  1  divide-by-zero flag. Valid with done; held until the next accepted start.
- d_load  out  1  capture operands into the input registers.
- r_load, r_shift, r_snum, r_sync_reset  out  1 each  R register controls.
- q_load, q_shift, q_snum  out  1 each  Q register controls.
- alu_sub  out  1  1 = subtract, 0 = add.
- q_bit  out  1  new quotient/root bit shifted into Q.

## Operation
- States: IDLE, LOAD, SHIFT, UPDATE, CORRECT, DONE. Encoding is free.
- Iteration count: N = WORD_LENGTH for divide, N = WORD_LENGTH/2 for sqrt.
- IDLE: all outputs 0 except error, which holds. On start=1, latch op, clear error, and go to LOAD.
- LOAD:
  - Assert d_load, q_load, r_load and r_sync_reset. This clears R and loads Q with the dividend or radicand.
  - Set counter to N.
  - If op=0 and div_zero=1: set error=1 and go to DONE.
  - Otherwise go to SHIFT.
- SHIFT:
  - Assert r_shift and q_shift.
  - r_snum = q_snum = op: 1-bit shift for divide, 2-bit shift for sqrt.
  - Go to UPDATE.
- UPDATE:
  - Assert r_load, q_load, r_shift and q_shift so the shifted values are captured.
  - alu_sub = ~r_sign, using the sign before the update.
  - q_bit = ~res_sign.
  - Decrement the counter. If the counter reaches 0, go to CORRECT; else go to SHIFT.
- CORRECT:
  - If r_sign=1: assert r_load with alu_sub=0 to add back the divisor or trial root.
  - If r_sign=0: no load.
  - Go to DONE.
- DONE: done=1; go to IDLE unconditionally. start in DONE is ignored.
- start while busy is ignored; no queuing.
- Outputs not listed for a state are 0.

## Timing
- Reset value: state IDLE, counter 0, op 0, and every output 0, including error.
- Reset asserted mid-operation: IDLE on the next edge. No done pulse. The datapath is left as-is.
- Normal latency: the start edge is cycle 0. LOAD is cycle 1, iterations occupy cycles 2..2N+1, CORRECT is cycle 2N+2, and done=1 in cycle 2N+3.
  - Divide, WORD_LENGTH=16: done at cycle 35.
  - Sqrt, WORD_LENGTH=16: done at cycle 19.
- Divide-by-zero latency: LOAD in cycle 1, done=1 with error=1 in cycle 2.
- Back-to-back: with start held high, the next LOAD occurs 2 cycles after DONE (DONE→IDLE→LOAD).
- busy rises the cycle after the start edge and falls the cycle after DONE.
- Control outputs are registered on the state. q_bit and alu_sub are combinational from res_sign/r_sign during UPDATE/CORRECT.

## Test plan
- Divide: dividend 100, divisor 7, WORD_LENGTH=16, res_sign driven from a reference model → done at cycle 35, Q=14, R=2, error=0, exactly 16 SHIFT/UPDATE pairs.
- Sqrt: radicand 144 → done at cycle 19, root=12, remainder 0, r_snum=q_snum=1 in every SHIFT/UPDATE, 8 pairs.
- Divide by zero: dividend 55, div_zero=1 → done and error high at cycle 2, no SHIFT state entered, error stays 1 until the next start.
- Start while busy: pulse start at cycles 5 and 20 of a divide → ignored, done only at cycle 35, latched op unchanged.
- Reset mid-op: assert reset at cycle 10 of a sqrt → all outputs 0 and busy=0 at cycle 11, no done. A new start at cycle 12 completes normally at cycle 31.
- Final correction: dividend 7, divisor 9 → r_sign=1 after the last iteration, CORRECT asserts r_load with alu_sub=0, result Q=0, R=7.

Source files
------------

// File: rtl/sqrt_div_sequencer.sv
// Control FSM for the shared R/Q shift-register datapath. It sequences a
// non-restoring integer divide or square root and holds only state, the
// iteration counter and the latched op.
module sqrt_div_sequencer #(
    parameter int WORD_LENGTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic op,
    input  logic div_zero,
    input  logic res_sign,
    input  logic r_sign,
    output logic busy,
    output logic done,
    output logic error,
    output logic d_load,
    output logic r_load,
    output logic r_shift,
    output logic r_snum,
    output logic r_sync_reset,
    output logic q_load,
    output logic q_shift,
    output logic q_snum,
    output logic alu_sub,
    output logic q_bit
);
    localparam int CNT_W = $clog2(WORD_LENGTH) + 1;
    localparam logic [CNT_W-1:0] N_DIV   = CNT_W'(WORD_LENGTH);
    localparam logic [CNT_W-1:0] N_SQRT  = CNT_W'(WORD_LENGTH / 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_UPDATE  = 3'd3;
    localparam logic [2:0] S_CORRECT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_op;
    logic             r_error;

    // Next-state selection; the counter guard uses <= so a corrupted zero count still exits.
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (start) w_next_state = S_LOAD;
                else       w_next_state = S_IDLE;
            end
            S_LOAD: begin
                if (!r_op && div_zero) w_next_state = S_DONE;
                else                   w_next_state = S_SHIFT;
            end
            S_SHIFT:   w_next_state = S_UPDATE;
            S_UPDATE: begin
                if (r_cnt <= CNT_ONE) w_next_state = S_CORRECT;
                else                  w_next_state = S_SHIFT;
            end
            S_CORRECT: w_next_state = S_DONE;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // State, iteration counter, latched op and sticky divide-by-zero flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_error <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_cnt <= r_op ? N_SQRT : N_DIV;
                    if (!r_op && div_zero) r_error <= 1'b1;
                end
                S_UPDATE: r_cnt <= r_cnt - CNT_ONE;
                default: ;
            endcase
        end
    end

    // Datapath controls decoded from the state register; sign-driven terms stay combinational.
    always_comb begin
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        error        = r_error;
        d_load       = 1'b0;
        r_load       = 1'b0;
        r_shift      = 1'b0;
        r_snum       = 1'b0;
        r_sync_reset = 1'b0;
        q_load       = 1'b0;
        q_shift      = 1'b0;
        q_snum       = 1'b0;
        alu_sub      = 1'b0;
        q_bit        = 1'b0;
        case (r_state)
            S_LOAD: begin
                d_load       = 1'b1;
                q_load       = 1'b1;
                r_load       = 1'b1;
                r_sync_reset = 1'b1;
            end
            S_SHIFT: begin
                r_shift = 1'b1;
                q_shift = 1'b1;
                r_snum  = r_op;
                q_snum  = r_op;
            end
            S_UPDATE: begin
                r_load  = 1'b1;
                q_load  = 1'b1;
                r_shift = 1'b1;
                q_shift = 1'b1;
                r_snum  = r_op;
                q_snum  = r_op;
                alu_sub = ~r_sign;
                q_bit   = ~res_sign;
            end
            S_CORRECT: begin
                if (r_sign) r_load = 1'b1;
                else        r_load = 1'b0;
                alu_sub = 1'b0;
            end
            S_DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule
